// File: rtl/kselect_iter.sv
// rtl/kselect_iter.sv - iterative k-of-n set-bit selector, one bit per cycle, lowest- or highest-first.
// Optional out_count port enabled by defining KSELECT_ITER_COUNT_EN.
module kselect_iter #(
    parameter int WIDTH = 128,
    parameter int K_MAX = 8,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic [KW-1:0]    in_k,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_valid,
`ifdef KSELECT_ITER_COUNT_EN
    output logic [KW-1:0]    out_count,
`endif
    input  logic             out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [KW-1:0] K_MAX_W = KW'(K_MAX);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [KW-1:0]    r_k, w_k_nxt;
    logic             r_dir, w_dir_nxt;

    logic [WIDTH-1:0] w_lo, w_hi, w_rev, w_rev_low, w_pick;
    logic [KW-1:0]    w_k_clamp;

`ifdef KSELECT_ITER_COUNT_EN
    logic [KW-1:0]    r_count, w_count_nxt;
    assign out_count = r_count;
`endif

    // Highest set bit found by reversing rem, isolating its lowest bit, and reversing back.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_rev
            assign w_rev[g]          = r_rem[WIDTH-1-g];
            assign w_hi[WIDTH-1-g]   = w_rev_low[g];
        end
    endgenerate

    assign w_rev_low = w_rev & (~w_rev + WIDTH'(1));
    assign w_lo      = r_rem & (~r_rem + WIDTH'(1));
    assign w_pick    = r_dir ? w_hi : w_lo;
    assign w_k_clamp = (in_k > K_MAX_W) ? K_MAX_W : in_k;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign out_vec   = r_acc;
    assign out_rem   = r_rem;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_acc_nxt   = r_acc;
        w_k_nxt     = r_k;
        w_dir_nxt   = r_dir;
`ifdef KSELECT_ITER_COUNT_EN
        w_count_nxt = r_count;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_rem_nxt   = in_vec;
                    w_acc_nxt   = '0;
                    w_k_nxt     = w_k_clamp;
                    w_dir_nxt   = in_dir;
`ifdef KSELECT_ITER_COUNT_EN
                    w_count_nxt = '0;
`endif
                    if (w_k_clamp == '0 || in_vec == '0)
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_rem_nxt = r_rem & ~w_pick;
                w_acc_nxt = r_acc | w_pick;
                w_k_nxt   = r_k - KW'(1);
`ifdef KSELECT_ITER_COUNT_EN
                w_count_nxt = r_count + KW'(1);
`endif
                if (w_k_nxt == '0 || w_rem_nxt == '0)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_dir   <= 1'b0;
`ifdef KSELECT_ITER_COUNT_EN
            r_count <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_acc   <= w_acc_nxt;
            r_k     <= w_k_nxt;
            r_dir   <= w_dir_nxt;
`ifdef KSELECT_ITER_COUNT_EN
            r_count <= w_count_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_kselect_iter.sv
// tb/tb_kselect_iter.sv - directed self-checking bench for kselect_iter (WIDTH=16, K_MAX=8).
module tb_kselect_iter;

    localparam int WIDTH = 16;
    localparam int K_MAX = 8;
    localparam int KW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_vec;
    logic [KW-1:0]    in_k;
    logic             in_dir;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_vec;
    logic [WIDTH-1:0] out_rem;
    logic             out_valid;
    logic             out_ready;
`ifdef KSELECT_ITER_COUNT_EN
    logic [KW-1:0]    out_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kselect_iter #(.WIDTH(WIDTH), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_k      (in_k),
        .in_dir    (in_dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_rem   (out_rem),
        .out_valid (out_valid),
`ifdef KSELECT_ITER_COUNT_EN
        .out_count (out_count),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input string name, input logic [15:0] vec, input logic [3:0] k,
                           input logic dir, input logic [15:0] exp_vec, input logic [15:0] exp_rem,
                           input int exp_cnt, input int exp_lat, input int hold);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_vec   = vec;
        in_k     = k;
        in_dir   = dir;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 16'h5A5A;
        in_k     = 4'hF;
        in_dir   = ~dir;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " out_vec"}, 32'(out_vec), 32'(exp_vec));
        check({name, " out_rem"}, 32'(out_rem), 32'(exp_rem));
        check({name, " cover"}, 32'(out_vec | out_rem), 32'(vec));
        check({name, " disjoint"}, 32'(out_vec & out_rem), 32'd0);
        check({name, " in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef KSELECT_ITER_COUNT_EN
        check({name, " out_count"}, 32'(out_count), 32'(exp_cnt));
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({name, " hold_vec"}, 32'(out_vec), 32'(exp_vec));
            check({name, " hold_rem"}, 32'(out_rem), 32'(exp_rem));
            check({name, " hold_valid"}, 32'(out_valid), 32'd1);
            check({name, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " valid_after_hs"}, 32'(out_valid), 32'd0);
        check({name, " ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_vec    = '0;
        in_k      = '0;
        in_dir    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_vec", 32'(out_vec), 32'd0);
        check("rst out_rem", 32'(out_rem), 32'd0);
        rst = 1'b0;
        #1;

        run_job("lo2",   16'h00F0, 4'd2,  1'b0, 16'h0030, 16'h00C0, 2, 2, 0);
        run_job("hi2",   16'h00F0, 4'd2,  1'b1, 16'h00C0, 16'h0030, 2, 2, 0);
        run_job("empty", 16'h0005, 4'd8,  1'b0, 16'h0005, 16'h0000, 2, 2, 0);
        run_job("k0",    16'h8001, 4'd0,  1'b0, 16'h0000, 16'h8001, 0, 0, 0);
        run_job("vec0",  16'h0000, 4'd3,  1'b0, 16'h0000, 16'h0000, 0, 0, 0);
        run_job("clamp", 16'hFFFF, 4'd15, 1'b0, 16'h00FF, 16'hFF00, 8, 8, 5);
        run_job("hi3",   16'hA5A5, 4'd3,  1'b1, 16'hA400, 16'h01A5, 3, 3, 0);

        // Abort during the third BUSY step.
        in_vec   = 16'hFFFF;
        in_k     = 4'd8;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort partial acc", 32'(out_vec), 32'h0003);
        rst = 1'b1;
        #1;
        check("abort out_vec", 32'(out_vec), 32'd0);
        check("abort out_rem", 32'(out_rem), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
`ifdef KSELECT_ITER_COUNT_EN
        check("abort out_count", 32'(out_count), 32'd0);
`endif
        @(posedge clk); #1;
        check("abort held valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        run_job("post_rst", 16'h00F0, 4'd2, 1'b0, 16'h0030, 16'h00C0, 2, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
